// File: rtl/datapath_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_fsm
// Control-path partner of the nibble-packing datapath. On a start request it
// pulses the datapath's clr, then holds en until the datapath reports done.
// It then captures the packed byte, splits it into its two operands and offers
// them downstream on a one-deep valid/ready register. If done does not arrive
// within TIMEOUT wait cycles, the transfer is abandoned and a sticky err is raised.
//
// Optional build macro: DATAPATH_CTRL_PARITY_EN
//   When defined, adds out_par (XOR of the captured byte) and par_odd_cnt
//   (count of accepted transfers whose out_par was 1, wrapping at 8 bits).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   transfer request, honoured only when idle
//   busy        out  high in every state except IDLE
//   dp_clr      out  datapath clr
//   dp_en       out  datapath en
//   dp_done     in   datapath done
//   dp_data     in   datapath packed byte (2*NIB_W)
//   out_a       out  upper operand of the captured byte
//   out_b       out  lower operand of the captured byte
//   out_valid   out  out_a/out_b valid
//   out_ready   in   downstream accept
//   err         out  sticky done-timeout flag
//   out_par     out  (parity build) XOR of the captured byte
//   par_odd_cnt out  (parity build) accepted transfers with out_par=1
// -----------------------------------------------------------------------------
module datapath_ctrl_fsm #(
    parameter int NIB_W   = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               dp_clr,
    output logic               dp_en,
    input  logic               dp_done,
    input  logic [2*NIB_W-1:0] dp_data,
    output logic [NIB_W-1:0]   out_a,
    output logic [NIB_W-1:0]   out_b,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef DATAPATH_CTRL_PARITY_EN
    output logic               out_par,
    output logic [7:0]         par_odd_cnt,
`endif
    output logic               err
);

    localparam int DW = 2 * NIB_W;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_EN   = 3'd2,
        S_WAIT = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_clr;
    logic               r_en;
    logic [NIB_W-1:0]   r_a;
    logic [NIB_W-1:0]   r_b;
    logic               r_valid;
    logic               r_err;

`ifdef DATAPATH_CTRL_PARITY_EN
    logic               r_par;
    logic [7:0]         r_par_cnt;

    // Even/odd parity of a packed byte.
    function automatic logic f_parity(input logic [DW-1:0] d);
        return ^d;
    endfunction
`endif

    // Transfer sequencer: state, timeout counter and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_busy    <= 1'b0;
            r_clr     <= 1'b0;
            r_en      <= 1'b0;
            r_a       <= {NIB_W{1'b0}};
            r_b       <= {NIB_W{1'b0}};
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
`ifdef DATAPATH_CTRL_PARITY_EN
            r_par     <= 1'b0;
            r_par_cnt <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_CLR;
                        r_busy  <= 1'b1;
                        r_clr   <= 1'b1;
                        r_err   <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CLR: begin
                    r_clr   <= 1'b0;
                    r_en    <= 1'b1;
                    r_state <= S_EN;
                end
                S_EN: begin
                    // The datapath latches its byte on this edge; en stays high in WAIT.
                    r_cnt   <= {CNT_W{1'b0}};
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so it wins over a same-cycle timeout.
                    if (dp_done) begin
                        r_a     <= dp_data[DW-1:NIB_W];
                        r_b     <= dp_data[NIB_W-1:0];
`ifdef DATAPATH_CTRL_PARITY_EN
                        r_par   <= f_parity(dp_data);
`endif
                        r_valid <= 1'b1;
                        r_en    <= 1'b0;
                        r_state <= S_HOLD;
                    end else if (r_cnt == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`ifdef DATAPATH_CTRL_PARITY_EN
                        if (r_par) begin
                            r_par_cnt <= r_par_cnt + 8'd1;
                        end else begin
                            r_par_cnt <= r_par_cnt;
                        end
`endif
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_clr   <= 1'b0;
                    r_en    <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign dp_clr    = r_clr;
    assign dp_en     = r_en;
    assign out_a     = r_a;
    assign out_b     = r_b;
    assign out_valid = r_valid;
    assign err       = r_err;
`ifdef DATAPATH_CTRL_PARITY_EN
    assign out_par     = r_par;
    assign par_odd_cnt = r_par_cnt;
`endif

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_datapath_ctrl_fsm
// Directed bench for datapath_ctrl_fsm. A small behavioural datapath latches
// the next byte from src_bytes when en first rises, and raises done on the
// done_at-th WAIT cycle (done_at=0: never). dp_data is X whenever en is low.
// -----------------------------------------------------------------------------
module tb_datapath_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, dp_clr, dp_en;
    logic       dp_done;
    logic [7:0] dp_data;
    logic [3:0] out_a, out_b;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       err;
`ifdef DATAPATH_CTRL_PARITY_EN
    logic       out_par;
    logic [7:0] par_odd_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int exp_odd = 0;

    always #5 clk = ~clk;

    datapath_ctrl_fsm #(.NIB_W(4), .TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .dp_clr(dp_clr), .dp_en(dp_en), .dp_done(dp_done), .dp_data(dp_data),
        .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DATAPATH_CTRL_PARITY_EN
        .out_par(out_par), .par_odd_cnt(par_odd_cnt),
`endif
        .err(err)
    );

    // Behavioural datapath model.
    logic [7:0] src_bytes [0:15];
    int         src_idx = 0;
    int         en_cnt = 0;
    int         done_at = 1;
    logic [7:0] lat_byte = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cnt <= 0;
        end else if (!dp_en) begin
            en_cnt <= 0;
        end else begin
            en_cnt <= en_cnt + 1;
            if (en_cnt == 0) begin
                lat_byte <= src_bytes[src_idx];
                src_idx  <= (src_idx + 1) % 16;
            end
        end
    end

    assign dp_done = (done_at != 0) && (en_cnt >= done_at);
    assign dp_data = (en_cnt != 0) ? lat_byte : 8'hxx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data_v;
        int         done_at;
        int         ready_wait;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        int         exp_lat;
        logic       exp_err;
    } vec_t;

    // One transfer from IDLE; leaves the DUT back in IDLE.
    task automatic run_vec(input vec_t v);
        int n;
        logic seen;
        src_bytes[src_idx] = v.data_v;
        done_at   = v.done_at;
        out_ready = 1'b0;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        @(negedge clk); n = 1;
        start = 1'b0;
        chk("clr_phase", {30'd0, dp_clr, dp_en}, 32'd2);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        chk("err_cleared_by_start", {31'd0, err}, 32'd0);
        @(negedge clk); n = 2;
        chk("en_phase", {30'd0, dp_clr, dp_en}, 32'd1);
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk); n++;
            if (out_valid || !busy) seen = 1'b1;
            else chk("wait_en_held", {30'd0, dp_clr, dp_en}, 32'd1);
        end
        chk("latency", n, v.exp_lat);
        chk("err_flag", {31'd0, err}, {31'd0, v.exp_err});
        chk("valid_flag", {31'd0, out_valid}, {31'd0, !v.exp_err});
        chk("en_dropped", {31'd0, dp_en}, 32'd0);
        if (out_valid) begin
            chk("out_a", {28'd0, out_a}, {28'd0, v.exp_a});
            chk("out_b", {28'd0, out_b}, {28'd0, v.exp_b});
`ifdef DATAPATH_CTRL_PARITY_EN
            chk("out_par", {31'd0, out_par}, {31'd0, ^v.data_v});
`endif
            for (int i = 0; i < v.ready_wait; i++) begin
                start = 1'b1;       // ignored while holding
                @(negedge clk);
                chk("hold_stable", {22'd0, out_valid, dp_en, dp_clr, busy, out_a, out_b},
                    {22'd0, 1'b1, 1'b0, 1'b0, 1'b1, v.exp_a, v.exp_b});
            end
            start = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (^v.data_v) exp_odd = (exp_odd + 1) % 256;
            chk("accept_valid_low", {31'd0, out_valid}, 32'd0);
            chk("accept_idle", {31'd0, busy}, 32'd0);
`ifdef DATAPATH_CTRL_PARITY_EN
            chk("par_odd_cnt", {24'd0, par_odd_cnt}, exp_odd);
`endif
            @(negedge clk);
            chk("no_relaunch", {30'd0, busy, dp_clr}, 32'd0);
        end else begin
            chk("timeout_idle", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("timeout_no_valid", {31'd0, out_valid}, 32'd0);
            chk("timeout_err_sticky", {31'd0, err}, 32'd1);
        end
    endtask

    vec_t vecs [0:5];
    int   hits [0:2];
    int   nhit;
    logic [7:0] b2b [0:2];

    initial begin
        // data, done_at, ready_wait, exp_a, exp_b, latency, err
        vecs[0] = '{8'hA5, 1, 0,  4'hA, 4'h5, 4,  1'b0};   // basic, minimum latency
        vecs[1] = '{8'h3C, 3, 10, 4'h3, 4'hC, 6,  1'b0};   // late done + backpressure
        vecs[2] = '{8'h77, 0, 0,  4'h0, 4'h0, 18, 1'b1};   // timeout after 15 WAIT cycles
        vecs[3] = '{8'h96, 15, 0, 4'h9, 4'h6, 18, 1'b0};   // done on last WAIT cycle wins
        vecs[4] = '{8'h07, 14, 2, 4'h0, 4'h7, 17, 1'b0};   // odd parity byte
        vecs[5] = '{8'hE1, 2, 1,  4'hE, 4'h1, 5,  1'b0};

        for (int i = 0; i < 16; i++) src_bytes[i] = 8'h00;

        // Reset state
        #2;
        chk("rst_outputs", {19'd0, busy, dp_clr, dp_en, out_valid, err, out_a, out_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {28'd0, busy, dp_clr, dp_en, out_valid}, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset while waiting for done: outputs clear asynchronously.
        done_at = 0;
        src_bytes[src_idx] = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_en", {31'd0, dp_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {28'd0, dp_en, busy, out_valid, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_odd = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {29'd0, out_valid, busy, dp_en}, 32'd0);
        end

        // Back-to-back with start and ready held high.
        b2b[0] = 8'h12; b2b[1] = 8'hFF; b2b[2] = 8'h00;
        for (int i = 0; i < 3; i++) src_bytes[(src_idx + i) % 16] = b2b[i];
        done_at   = 1;
        start     = 1'b1;
        out_ready = 1'b1;
        nhit = 0;
        for (int n = 1; n < 30 && nhit < 3; n++) begin
            @(negedge clk);
            if (out_valid) begin
                hits[nhit] = n;
                chk("b2b_a", {28'd0, out_a}, {28'd0, b2b[nhit][7:4]});
                chk("b2b_b", {28'd0, out_b}, {28'd0, b2b[nhit][3:0]});
`ifdef DATAPATH_CTRL_PARITY_EN
                chk("b2b_par", {31'd0, out_par}, 32'd0);
`endif
                nhit++;
                if (nhit == 3) start = 1'b0;
            end
        end
        chk("b2b_count", nhit, 3);
        if (nhit == 3) begin
            chk("b2b_first", hits[0], 4);
            chk("b2b_gap1", hits[1] - hits[0], 5);
            chk("b2b_gap2", hits[2] - hits[1], 5);
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_done_idle", {30'd0, busy, out_valid}, 32'd0);
`ifdef DATAPATH_CTRL_PARITY_EN
        chk("b2b_par_cnt", {24'd0, par_odd_cnt}, 32'd0);
`endif
        @(negedge clk);

        // Odd-parity byte after the even ones.
        run_vec('{8'h01, 1, 0, 4'h0, 4'h1, 4, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl_fsm.md
Name: datapath_ctrl_fsm

Overview:
- Control-path partner of the packing datapath; the datapath packs two nibbles into one byte.
- Receives a `start` request and drives the datapath's `clr`/`en` pins in the correct order.
- Waits for the datapath's `done`, captures the packed byte and splits it back into its two operands.
- Presents the two operands downstream on a one-deep valid/ready output register. A done-timeout flags a stalled datapath.

Parameters:
- NIB_W, 4, width of each unpacked operand; packed word is 2*NIB_W.
- TIMEOUT, 15, max cycles in WAIT without `done` before error; must be >=1.
- CNT_W, 4, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one transfer; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- dp_clr  out  1  to datapath `clr`.
- dp_en  out  1  to datapath `en`.
- dp_done  in  1  from datapath `done`.
- dp_data  in  2*NIB_W  from datapath packed output; may be high-Z outside EN/WAIT.
- out_a  out  NIB_W  upper nibble of captured byte (dp_data[2*NIB_W-1:NIB_W]).
- out_b  out  NIB_W  lower nibble of captured byte (dp_data[NIB_W-1:0]).
- out_valid  out  1  out_a/out_b valid.
- out_ready  in  1  downstream accepts when high with out_valid.
- err  out  1  sticky timeout flag; cleared only by next accepted start or reset.

Behaviour:
- Reset (rst_n low, async): state=IDLE, dp_clr=0, dp_en=0, out_a=0, out_b=0, out_valid=0, err=0, busy=0, counter=0. Reset mid-transfer aborts immediately; no partial output.
- All outputs are registered; state decode drives dp_clr/dp_en from registers, not from combinational logic on inputs.
- IDLE: dp_en=0, dp_clr=0. On start=1 -> CLR, err<=0.
- CLR (1 cycle): dp_clr=1, dp_en=0 -> EN. The datapath's `done` is not cleared by `clr`, so it is never trusted before WAIT.
- EN (1 cycle): dp_en=1, dp_clr=0; the datapath latches its byte at the edge leaving EN. Counter<=0 -> WAIT.
- WAIT: dp_en=1 held.
  - If dp_done=1: out_a/out_b <= split of dp_data, out_valid<=1 -> HOLD.
  - Else if counter==TIMEOUT-1: err<=1, dp_en<=0 -> IDLE.
  - Else counter+1.
  - dp_done and timeout on the same cycle: dp_done wins (capture, no err).
- HOLD: dp_en=0, dp_clr=0, out_valid=1, out_a/out_b stable.
  - On out_ready=1: out_valid<=0 -> IDLE.
  - out_ready high before out_valid: no effect.
- start asserted outside IDLE is ignored, not queued.
- Minimum latency start -> out_valid: 4 cycles (IDLE->CLR->EN->WAIT->HOLD), with dp_done high in the first WAIT cycle.
- Back-to-back: start held high re-launches on the cycle after the HOLD handshake returns to IDLE; max throughput is one transfer per 5 cycles.
- dp_data is sampled only in WAIT with dp_done=1; X/Z elsewhere must never propagate to out_a/out_b.
- Counter saturates at TIMEOUT-1; it never wraps within a transfer.

Optional Feature:
- Macro: DATAPATH_CTRL_PARITY_EN.
- Defined:
  - Adds output `out_par` (1 bit) = XOR of the full captured byte. It is registered with out_a/out_b, reset to 0 and stable in HOLD.
  - Adds output `par_odd_cnt` (8 bits): counts accepted transfers with out_par=1. It wraps at 255->0 and resets to 0.
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset mid-WAIT: rst_n low while dp_en=1 -> same cycle async: dp_en=0, busy=0, out_valid=0, err=0; no later output.
- Basic transfer: start pulse, model datapath with A=4'hA, B=4'h5, done one cycle after en -> dp_clr high exactly 1 cycle, then out_valid at cycle 4 with out_a=4'hA, out_b=4'h5.
- Backpressure: out_ready low 10 cycles after out_valid -> out_a/out_b held stable; dp_en=0 throughout; one ready pulse -> out_valid=0 next cycle, state IDLE.
- Timeout: datapath never asserts done, TIMEOUT=15 -> err=1 after exactly 15 WAIT cycles, dp_en drops, out_valid never rises; next start clears err.
- Simultaneous: dp_done rises on the 15th WAIT cycle -> capture occurs, err stays 0. start during HOLD -> ignored; no second transfer.
- Back-to-back with start held high, 3 transfers of bytes 8'h12, 8'hFF, 8'h00 -> 3 outputs in order, 5 cycles apart. With DATAPATH_CTRL_PARITY_EN: out_par=0,0,0 and par_odd_cnt=0; repeat with 8'h01 -> out_par=1, par_odd_cnt=1.
